// File: rtl/mem_io_responder_if.sv
// Processor-side memory bus: word address, write data and strobe out, registered read data back.
interface mem_io_responder_if;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] DIN;

  modport master (
    output ADDR,
    output DOUT,
    output W,
    input  DIN
  );

  modport slave (
    input  ADDR,
    input  DOUT,
    input  W,
    output DIN
  );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-bus responder: on-chip RAM, LED register, synchronized switches and an interval timer,
// all returned through a single registered read port with one cycle of latency.
module mem_io_responder #(
  parameter int unsigned AW       = 8,
  parameter int unsigned PRESCALE = 50000
) (
  input  logic               Clock,
  input  logic               Resetn,
  mem_io_responder_if.slave  bus,
  input  logic [9:0]         SW,
  output logic [9:0]         LEDR,
  output logic               TIRQ
);

  localparam int unsigned    PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PresLast = PW'(PRESCALE - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;

  logic [15:0]   mem [2**AW];
  logic [AW-1:0] ram_idx;
  logic [3:0]    region;
  logic [1:0]    tmr_reg;
  logic          sel_ram, sel_led, sel_tmr;
  logic          wr_ram, wr_led, wr_load, wr_ctrl, wr_stat;

  logic [15:0]   rd_data, din_q;
  logic [9:0]    led_q;
  logic [9:0]    sw_meta_q, sw_sync_q;

  logic [15:0]   reload_q, reload_d;
  logic [15:0]   count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          run_q, run_d;
  logic          auto_q, auto_d;
  logic          done_q, done_d;
  logic          tick, expire;

  logic          unused_addr;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign region      = bus.ADDR[15:12];
  assign ram_idx     = bus.ADDR[AW-1:0];
  assign tmr_reg     = bus.ADDR[1:0];
  assign unused_addr = ^bus.ADDR[11:AW];

  assign sel_ram = (region == 4'h0);
  assign sel_led = (region == 4'h1);
  assign sel_tmr = (region == 4'h2);

  assign wr_ram  = bus.W & sel_ram;
  assign wr_led  = bus.W & sel_led;
  assign wr_load = bus.W & sel_tmr & (tmr_reg == 2'd0);
  assign wr_ctrl = bus.W & sel_tmr & (tmr_reg == 2'd1);
  assign wr_stat = bus.W & sel_tmr & (tmr_reg == 2'd2);

  // ---------------------------------------------------------------------------
  // RAM: no reset, read-first because the read path samples the old word
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (wr_ram) begin
      mem[ram_idx] <= bus.DOUT;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and registered read data
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    case (region)
      4'h0: rd_data = mem[ram_idx];
      4'h1: rd_data = {6'b0, led_q};
      4'h2: begin
        case (tmr_reg)
          2'd0:    rd_data = reload_q;
          2'd1:    rd_data = {14'b0, auto_q, run_q};
          2'd2:    rd_data = {15'b0, done_q};
          default: rd_data = count_q;
        endcase
      end
      4'h3:    rd_data = {6'b0, sw_sync_q};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      din_q     <= '0;
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      din_q     <= rd_data;
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
      if (wr_led) begin
        led_q <= bus.DOUT[9:0];
      end
    end
  end

  assign bus.DIN = din_q;
  assign LEDR    = led_q;

  // ---------------------------------------------------------------------------
  // Interval timer datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    tick     = (state_q == StRun) && (presc_q == PresLast);
    expire   = tick && (count_q == '0);
    presc_d  = presc_q;
    count_d  = count_q;
    reload_d = reload_q;
    run_d    = run_q;
    auto_d   = auto_q;
    done_d   = done_q;

    if (state_q == StRun) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - 16'd1;
      end else if (auto_q) begin
        count_d = reload_q;
      end else begin
        run_d = 1'b0;
      end
    end

    // Bus writes override the tick so a LOAD restarts cleanly and a CTRL write decides RUN.
    if (wr_load) begin
      reload_d = bus.DOUT;
      count_d  = bus.DOUT;
      presc_d  = '0;
    end
    if (wr_ctrl) begin
      run_d  = bus.DOUT[0];
      auto_d = bus.DOUT[1];
    end

    if (wr_stat && bus.DOUT[0]) begin
      done_d = 1'b0;
    end
    if (expire) begin
      done_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Timer FSM: follows the RUN bit as it will be after this edge
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (run_d) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!run_d) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= StIdle;
      reload_q <= '0;
      count_q  <= '0;
      presc_q  <= '0;
      run_q    <= 1'b0;
      auto_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      run_q    <= run_d;
      auto_q   <= auto_d;
      done_q   <= done_d;
    end
  end

  assign TIRQ = done_q;

endmodule
